clk_div_monitor: RTL

- Receiving-end checker for a divided clock generated elsewhere in the FPGA design.
- Samples the slow clock in the fast clock domain and produces single-cycle rise and fall strobes, which downstream FFT control logic uses as clock enables.
- Measures the period and high time in fast cycles and checks them against the expected divide ratio.
- Reports lock status and a saturating error count for bring-up and debug.

---
 rtl/clk_div_monitor.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/clk_div_monitor.sv
// ---------------------------------------------------------------------------
// clk_div_monitor
//
// Receiving-end checker for a divided clock generated elsewhere in the FPGA.
// The slow clock is brought into the clock_in domain through a three-flop
// chain. Rising and falling edges are turned into single-cycle strobes that
// downstream logic can use as clock enables. Each period (rise to rise) and
// its high time are measured in clock_in cycles and checked against DIVISOR.
// A small lock FSM, a timeout and a saturating error counter report health.
//
// Parameters:
//   DIVISOR    expected slow period in clock_in cycles (>= 2); the expected
//              high time is DIVISOR/2
//   CNT_W      width of the period / high-time counters (2*DIVISOR < 2**CNT_W)
//   LOCK_COUNT consecutive good periods needed before locked asserts (>= 1)
//
// Ports:
//   clock_in     in   fast reference clock, rising edge
//   rst          in   synchronous active-high reset
//   clk_slow_in  in   divided clock under monitor (asynchronous to clock_in)
//   clear_err    in   synchronous clear of err_count
//   rise_pulse   out  one-cycle strobe per detected rising edge
//   fall_pulse   out  one-cycle strobe per detected falling edge
//   period_cnt   out  last measured period (clock_in cycles)
//   high_cnt     out  high time belonging to that period
//   period_valid out  strobe: period_cnt/high_cnt updated this cycle
//   period_err   out  strobe: bad period or timeout
//   locked       out  high while the lock FSM is in LOCKED
//   err_count    out  saturating error counter
// ---------------------------------------------------------------------------
module clk_div_monitor #(
  parameter int DIVISOR    = 5,
  parameter int CNT_W      = 8,
  parameter int LOCK_COUNT = 4
) (
  input  logic             clock_in,
  input  logic             rst,
  input  logic             clk_slow_in,
  input  logic             clear_err,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic             period_valid,
  output logic             period_err,
  output logic             locked,
  output logic [7:0]       err_count
);

  localparam logic [CNT_W-1:0] DIV_C     = CNT_W'(DIVISOR);
  localparam logic [CNT_W-1:0] HALF_C    = CNT_W'(DIVISOR / 2);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(2 * DIVISOR - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam int               GOOD_W    = $clog2(LOCK_COUNT + 1);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  // sync_reg[0] = s1, sync_reg[1] = s2, sync_reg[2] = s3
  logic [2:0]        sync_reg;
  logic [CNT_W-1:0]  run_cnt_reg;
  logic [CNT_W-1:0]  high_latch_reg;
  logic              armed_reg;
  logic              armed_next;
  logic [GOOD_W-1:0] good_cnt_reg;
  logic [GOOD_W-1:0] good_cnt_next;
  state_t            state_reg;
  state_t            state_next;
  logic [7:0]        err_count_next;

  logic             rise_det;
  logic             fall_det;
  logic [CNT_W-1:0] run_plus1;
  logic             period_end;
  logic             first_rise;
  logic             period_good;
  logic             timeout;
  logic             err_event;
  logic [7:0]       err_base;

  assign rise_det = sync_reg[1] & ~sync_reg[2];
  assign fall_det = ~sync_reg[1] & sync_reg[2];

  // run_cnt counts cycles since the last rise_det, so at the next rise_det
  // (or fall_det) run_cnt + 1 is the elapsed time from that rise.
  assign run_plus1   = run_cnt_reg + 1'b1;
  assign period_end  = rise_det & armed_reg;
  assign first_rise  = rise_det & ~armed_reg;
  assign period_good = (run_plus1 == DIV_C) && (high_latch_reg == HALF_C);
  // A rise on the timeout cycle still counts as a (bad) period, so the
  // timeout only fires when no rise arrives.
  assign timeout     = armed_reg & ~rise_det & (run_cnt_reg == TIMEOUT_C);
  assign err_event   = (period_end & ~period_good) | timeout;

  // Lock FSM next state and error counter next value
  always_comb begin
    state_next     = state_reg;
    good_cnt_next  = good_cnt_reg;
    armed_next     = armed_reg;
    err_base       = err_count;
    err_count_next = err_count;

    if (first_rise) begin
      // The first rise after reset or a timeout has no previous rise to
      // measure from; it only arms the measurement.
      armed_next    = 1'b1;
      state_next    = ST_ACQUIRE;
      good_cnt_next = '0;
    end else if (period_end) begin
      if (!period_good) begin
        state_next    = ST_ACQUIRE;
        good_cnt_next = '0;
      end else if (state_reg != ST_LOCKED) begin
        if (good_cnt_reg == GOOD_LAST) begin
          state_next    = ST_LOCKED;
          good_cnt_next = '0;
        end else begin
          good_cnt_next = good_cnt_reg + 1'b1;
        end
      end
    end else if (timeout) begin
      armed_next    = 1'b0;
      state_next    = ST_UNLOCKED;
      good_cnt_next = '0;
    end

    // Clear is applied before the increment, so clear plus error gives 1.
    if (clear_err) begin
      err_base = 8'd0;
    end
    if (err_event && (err_base != 8'hFF)) begin
      err_count_next = err_base + 8'd1;
    end else begin
      err_count_next = err_base;
    end
  end

  always_ff @(posedge clock_in) begin
    if (rst) begin
      sync_reg       <= '0;
      run_cnt_reg    <= '0;
      high_latch_reg <= '0;
      armed_reg      <= 1'b0;
      good_cnt_reg   <= '0;
      state_reg      <= ST_UNLOCKED;
      rise_pulse     <= 1'b0;
      fall_pulse     <= 1'b0;
      period_cnt     <= '0;
      high_cnt       <= '0;
      period_valid   <= 1'b0;
      period_err     <= 1'b0;
      locked         <= 1'b0;
      err_count      <= 8'd0;
    end else begin
      sync_reg <= {sync_reg[1:0], clk_slow_in};

      if (rise_det) begin
        run_cnt_reg <= '0;
      end else if (run_cnt_reg != CNT_MAX) begin
        run_cnt_reg <= run_plus1;
      end

      if (fall_det) begin
        high_latch_reg <= run_plus1;
      end

      rise_pulse   <= rise_det;
      fall_pulse   <= fall_det;
      period_valid <= period_end;
      if (period_end) begin
        period_cnt <= run_plus1;
        high_cnt   <= high_latch_reg;
      end
      period_err <= err_event;

      armed_reg    <= armed_next;
      good_cnt_reg <= good_cnt_next;
      state_reg    <= state_next;
      // Registered from the next state so locked moves on the same edge as
      // the state register, one cycle after rise_det.
      locked       <= (state_next == ST_LOCKED);
      err_count    <= err_count_next;
    end
  end

endmodule
